// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   keeps at most one instruction-memory request outstanding, and presents
//   either a fetched instruction (valid_o=1) or a NOP bubble (valid_o=0).
//
// Handshake semantics (instruction memory):
//   imem_req_o is a one-cycle pulse that carries imem_addr_o. The memory
//   answers exactly once per request with a one-cycle imem_rvalid_i pulse
//   carrying imem_rdata_i, at least one cycle after the request. No new
//   request is issued until the previous one has been answered, except that
//   the answering cycle itself may issue the next request (back-to-back).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall_i           hazard stall: hold IF/ID outputs and PC
//   redirect_i        taken branch/jump pulse, target on redirect_pc_i
//   imem_req_o        fetch request pulse, address on imem_addr_o
//   imem_rvalid_i     response pulse, instruction on imem_rdata_i
//   instr_o           instruction (or NOP_INSTR bubble) to IF/ID
//   pc_o              PC+4 of instr_o
//   valid_o           1 = instr_o is a real fetched instruction
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  // IDLE: issue request at pc_q; FETCH: waiting for response;
  // HOLD: response parked in buffer while stalled;
  // DISCARD: response still due but already invalidated by a redirect.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;          // address of the next / outstanding fetch
  logic [31:0] buf_q, buf_d;        // instruction parked during a stall
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        req_c;
  logic [31:0] addr_c;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    req_c    = 1'b0;
    addr_c   = '0;

    if (redirect_i) begin
      // Redirect beats stall and rvalid; any same-cycle response is dropped.
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      buf_d   = '0;
      // A request is still in flight only if no response arrives this cycle.
      if ((state_q == FETCH || state_q == DISCARD) && !imem_rvalid_i)
        state_d = DISCARD;
      else
        state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Prefetch proceeds even under stall; only the outputs freeze.
          req_c   = 1'b1;
          addr_c  = pc_q;
          state_d = FETCH;
          if (!stall_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        FETCH: begin
          if (imem_rvalid_i) begin
            pc_d = pc_plus4;
            if (!stall_i) begin
              instr_d  = imem_rdata_i;
              pc_out_d = pc_plus4;
              valid_d  = 1'b1;
              // Back-to-back request keeps a latency-1 memory at full rate.
              req_c    = 1'b1;
              addr_c   = pc_plus4;
            end else begin
              buf_d   = imem_rdata_i;
              state_d = HOLD;
            end
          end else if (!stall_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          // pc_q was already advanced when the word was parked.
          if (!stall_i) begin
            instr_d  = buf_q;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
        end
        DISCARD: begin
          if (imem_rvalid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gate with rst_n so the request disappears as soon as reset is asserted.
  assign imem_req_o  = req_c & rst_n;
  assign imem_addr_o = imem_req_o ? addr_c : 32'h0000_0000;

  assign instr_o = instr_q;
  assign pc_o    = pc_out_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The instruction memory is driven by
//   hand from the stimulus sequence (rdata = addr | 32'hA000_0000 unless
//   noted). A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap
//   and asynchronous reset mid-fetch.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        rvalid, rvalid2;
  logic [31:0] rdata, rdata2;

  logic        req, req2;
  logic [31:0] addr, addr2;
  logic [31:0] instr, instr2;
  logic [31:0] pc, pc2;
  logic        valid, valid2;

  int n_assert;
  int n_fail;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .instr_o      (instr),
    .pc_o         (pc),
    .valid_o      (valid)
  );

  if_fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(32'h0000_0000)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst2_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (req2),
    .imem_addr_o  (addr2),
    .imem_rvalid_i(rvalid2),
    .imem_rdata_i (rdata2),
    .instr_o      (instr2),
    .pc_o         (pc2),
    .valid_o      (valid2)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_instr,
                         input logic [31:0] e_pc, input logic e_valid);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".pc"},    pc,    e_pc);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
  endtask

  task automatic chk_req(input string tag, input logic e_req, input logic [31:0] e_addr);
    chk({tag, ".req"},  {31'd0, req}, {31'd0, e_req});
    chk({tag, ".addr"}, addr, e_addr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    rvalid      = 1'b0;
    rdata       = '0;
    rvalid2     = 1'b0;
    rdata2      = '0;

    // Reset state
    #12;
    chk_out("reset", 32'h0, 32'h0, 1'b0);
    chk_req("reset", 1'b0, 32'h0);

    // Release reset mid-cycle: IDLE requests at RESET_PC
    rst_n = 1'b1;
    #1;
    chk_req("idle0", 1'b1, 32'h0000_0000);

    // Latency-1 streaming
    next_cycle(); rvalid = 1'b1; rdata = 32'hA000_0000; #2;
    chk_req("stream0", 1'b1, 32'h0000_0004);
    chk("stream0.valid", {31'd0, valid}, 32'd0);

    next_cycle(); rdata = 32'hA000_0004; #2;
    chk_out("stream1", 32'hA000_0000, 32'h0000_0004, 1'b1);
    chk_req("stream1", 1'b1, 32'h0000_0008);

    next_cycle(); rdata = 32'hA000_0008; #2;
    chk_out("stream2", 32'hA000_0004, 32'h0000_0008, 1'b1);
    chk_req("stream2", 1'b1, 32'h0000_000C);

    // Stall for 3 cycles while the response for 0xC lands
    next_cycle(); rdata = 32'hA000_000C; stall = 1'b1; #2;
    chk_out("stall0", 32'hA000_0008, 32'h0000_000C, 1'b1);
    chk_req("stall0", 1'b0, 32'h0);

    next_cycle(); rvalid = 1'b0; rdata = '0; #2;
    chk_out("hold1", 32'hA000_0008, 32'h0000_000C, 1'b1);
    chk_req("hold1", 1'b0, 32'h0);

    next_cycle(); #2;
    chk_out("hold2", 32'hA000_0008, 32'h0000_000C, 1'b1);
    chk_req("hold2", 1'b0, 32'h0);

    next_cycle(); stall = 1'b0; #2;
    chk_out("hold3", 32'hA000_0008, 32'h0000_000C, 1'b1);
    chk_req("hold3", 1'b0, 32'h0);

    // Buffered word appears, then IDLE re-requests at 0x10
    next_cycle(); #2;
    chk_out("unbuf", 32'hA000_000C, 32'h0000_0010, 1'b1);
    chk_req("unbuf", 1'b1, 32'h0000_0010);

    next_cycle(); rvalid = 1'b1; rdata = 32'hA000_0010; #2;
    chk("bubble.valid", {31'd0, valid}, 32'd0);
    chk_req("resume", 1'b1, 32'h0000_0014);

    // Redirect while the fetch of 0x14 is outstanding
    next_cycle(); rvalid = 1'b0; rdata = '0; redirect = 1'b1; redirect_pc = 32'h0000_0103; #2;
    chk_out("redir0", 32'hA000_0010, 32'h0000_0014, 1'b1);
    chk_req("redir0", 1'b0, 32'h0);

    // Late response is dropped in DISCARD
    next_cycle(); redirect = 1'b0; redirect_pc = '0; rvalid = 1'b1; rdata = 32'hA000_0014; #2;
    chk("discard.valid", {31'd0, valid}, 32'd0);
    chk("discard.instr", instr, 32'h0);
    chk_req("discard", 1'b0, 32'h0);

    next_cycle(); rvalid = 1'b0; rdata = '0; #2;
    chk("after_discard.valid", {31'd0, valid}, 32'd0);
    chk("after_discard.instr", instr, 32'h0);
    chk_req("after_discard", 1'b1, 32'h0000_0100);

    // Redirect + stall + rvalid together: redirect wins, data dropped
    next_cycle(); redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_2002;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #2;
    chk_req("redir_stall", 1'b0, 32'h0);

    next_cycle(); redirect = 1'b0; stall = 1'b0; redirect_pc = '0; rvalid = 1'b0; rdata = '0; #2;
    chk_out("redir_stall_after", 32'h0, 32'h0000_0014, 1'b0);
    chk_req("redir_stall_after", 1'b1, 32'h0000_2000);

    // Latency-3 memory
    next_cycle(); #2;
    chk_req("lat3_wait1", 1'b0, 32'h0);
    next_cycle(); #2;
    chk_req("lat3_wait2", 1'b0, 32'h0);
    next_cycle(); rvalid = 1'b1; rdata = 32'hA000_2000; #2;
    chk_req("lat3_resp0", 1'b1, 32'h0000_2004);

    next_cycle(); rvalid = 1'b0; rdata = '0; #2;
    chk_out("lat3_out0", 32'hA000_2000, 32'h0000_2004, 1'b1);
    next_cycle(); #2;
    chk_out("lat3_bub1", 32'h0, 32'h0000_2004, 1'b0);
    next_cycle(); rvalid = 1'b1; rdata = 32'hA000_2004; #2;
    chk_out("lat3_bub2", 32'h0, 32'h0000_2004, 1'b0);
    next_cycle(); rvalid = 1'b0; rdata = '0; #2;
    chk_out("lat3_out1", 32'hA000_2004, 32'h0000_2008, 1'b1);

    // PC wrap and async reset mid-fetch on the second instance
    rst2_n = 1'b1;
    #1;
    chk("wrap.req", {31'd0, req2}, 32'd1);
    chk("wrap.addr0", addr2, 32'hFFFF_FFFC);

    next_cycle(); rvalid2 = 1'b1; rdata2 = 32'h5555_0000; #2;
    chk("wrap.addr1", addr2, 32'h0000_0000);

    next_cycle(); rvalid2 = 1'b0; rdata2 = '0; #2;
    chk("wrap.pc", pc2, 32'h0000_0000);
    chk("wrap.instr", instr2, 32'h5555_0000);
    chk("wrap.valid", {31'd0, valid2}, 32'd1);
    chk("wrap.req_fetch", {31'd0, req2}, 32'd0);

    // Second response lands, then reset asserted between clock edges
    rvalid2 = 1'b1; rdata2 = 32'h5555_0004;
    #1;
    chk("midreset.pre_req", {31'd0, req2}, 32'd1);
    rst2_n = 1'b0;
    #1;
    chk("midreset.instr", instr2, 32'h0);
    chk("midreset.pc", pc2, 32'h0);
    chk("midreset.valid", {31'd0, valid2}, 32'd0);
    chk("midreset.req", {31'd0, req2}, 32'd0);
    chk("midreset.addr", addr2, 32'h0);
    rvalid2 = 1'b0; rdata2 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
